// File: rtl/pausible_rx_port.sv
// Receive port for a pausible-clock domain: accepts 4-phase bundled-data words
// from an asynchronous sender, arbitrates the write against the local clock via
// the pausible_clock_sync mutex (req/grant), and buffers words in a show-ahead FIFO.
//
// Ports:
//   clock, rstn       pausible clock, asynchronous active-low reset
//   a_req, a_data     4-phase request and bundled data from the sender
//   a_ack             4-phase acknowledge to the sender (flop-driven)
//   req, grant        mutex request (flop-driven) / grant to and from the clock sync
//   out_valid/ready   consumer handshake, out_data is the buffer head word
//   fill_level        number of occupied buffer entries
module pausible_rx_port #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic                          a_req,
  input  logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_ack,
  output logic                          req,
  input  logic                          grant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    ack_q, ack_d;
  logic                    wr_en;
  logic                    pop;
  logic                    full;
  logic                    valid_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    a_req_s;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;

  // a_req synchronizer into the clock domain
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_req};
    end
  end

  assign a_req_s = sync_q[SYNC_STAGES-1];

  // A slot is only claimed from IDLE; while in REQUEST the count can only fall,
  // so the slot checked here is still free when the grant arrives.
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = valid_q && out_ready;

  // Handshake FSM state register
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

  // Handshake FSM next state; req/ack next values computed here, driven from flops
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req_s && !full) begin
          state_d = REQUEST;
          req_d   = 1'b1;
        end
      end
      REQUEST: begin
        if (grant) begin
          wr_en   = 1'b1;
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!a_req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  // Buffer pointers, occupancy and registered valid
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= a_data;
  end

  assign a_ack      = ack_q;
  assign req        = req_q;
  assign out_valid  = valid_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign fill_level = count_q;

endmodule

// File: tb/tb_pausible_rx_port.sv
// Self-checking bench for pausible_rx_port: directed scenarios plus a randomized
// sender/consumer/grant run, checked every cycle against a word-queue model.
module tb_pausible_rx_port;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic          clock = 1'b0;
  logic          rstn;
  logic          a_req;
  logic [DW-1:0] a_data;
  logic          a_ack;
  logic          req;
  logic          grant;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] fill_level;

  pausible_rx_port #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock     (clock),
    .rstn      (rstn),
    .a_req     (a_req),
    .a_data    (a_data),
    .a_ack     (a_ack),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill_level(fill_level)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_err    = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] pop_log[$];
  int            grant_mode = 0;  // 0 manual, 1 echo req, 2 random
  bit            rand_ready = 0;
  int            max_fill   = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            exp_ack;
    int            exp_fill;
  } bp_vec_t;

  bp_vec_t       bp_tab[5];
  logic [DW-1:0] bp_drain[4];
  logic [DW-1:0] wrap_tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: advance the word-queue model across the edge, then compare.
  task automatic tick();
    bit            pop_m;
    logic [DW-1:0] d_pre;
    logic          ack_pre;
    logic          areq_pre;
    pop_m    = (rstn === 1'b1) && (out_ready === 1'b1) && (model_q.size() != 0);
    if (rstn && out_valid && out_ready) pop_log.push_back(out_data);
    d_pre    = a_data;
    ack_pre  = a_ack;
    areq_pre = a_req;
    @(posedge clock);
    #1;
    if (!rstn) begin
      model_q.delete();
    end else begin
      if (pop_m) void'(model_q.pop_front());
      if (a_ack && !ack_pre) begin
        check("ack_only_while_a_req", 32'(areq_pre), 32'd1);
        model_q.push_back(d_pre);
      end
    end
    if (model_q.size() > max_fill) max_fill = model_q.size();
    check("fill_level", 32'(fill_level), 32'(model_q.size()));
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("out_data", 32'(out_data), 32'(model_q[0]));
    check("req_ack_exclusive", 32'(req & a_ack), 32'd0);
    case (grant_mode)
      1: grant = req;
      2: grant = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      default: ;
    endcase
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (a_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Complete one 4-phase handshake from the sender side.
  task automatic transfer(input logic [DW-1:0] d, input int budget);
    bit ok;
    int cyc;
    a_data = d;
    a_req  = 1'b1;
    wait_ack(1'b1, budget, ok, cyc);
    check("ack_rise_in_budget", 32'(ok), 32'd1);
    a_req  = 1'b0;
    a_data = ~d;
    wait_ack(1'b0, 20, ok, cyc);
    check("ack_fall_in_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int cyc;
    bp_tab[0] = '{8'h01, 1'b1, 1};
    bp_tab[1] = '{8'h02, 1'b1, 2};
    bp_tab[2] = '{8'h03, 1'b1, 3};
    bp_tab[3] = '{8'h04, 1'b1, 4};
    bp_tab[4] = '{8'h05, 1'b0, 4};
    bp_drain  = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 10; i++) wrap_tab[i] = 8'(8'h10 + i);

    rstn = 1'b0; a_req = 1'b0; a_data = '0; grant = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_req", 32'(req), 32'd0);
    check("rst_ack", 32'(a_ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    // Single transfer with grant one cycle after req
    grant_mode = 1;
    a_data = 8'hA5;
    a_req  = 1'b1;
    wait_ack(1'b1, 20, ok, cyc);
    check("single_ack", 32'(ok), 32'd1);
    check("single_latency", 32'(cyc), 32'(SS + 2));
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_fill", 32'(fill_level), 32'd1);
    a_req  = 1'b0;
    a_data = 8'h5A;
    wait_ack(1'b0, 20, ok, cyc);
    check("single_ack_drop", 32'(ok), 32'd1);
    check("single_drop_latency", 32'(cyc), 32'(SS + 1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drained", 32'(fill_level), 32'd0);

    // Back-pressure: fifth word must wait for a free slot
    for (int i = 0; i < 5; i++) begin
      a_data = bp_tab[i].data;
      a_req  = 1'b1;
      wait_ack(1'b1, 20, ok, cyc);
      check("bp_ack", 32'(ok), 32'(bp_tab[i].exp_ack));
      if (ok) begin
        a_req = 1'b0;
        wait_ack(1'b0, 20, ok, cyc);
        check("bp_ack_drop", 32'(ok), 32'd1);
      end
      check("bp_fill", 32'(fill_level), 32'(bp_tab[i].exp_fill));
    end
    check("bp_req_paused", 32'(req), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_ack(1'b1, 20, ok, cyc);
    check("bp_fifth_ack", 32'(ok), 32'd1);
    a_req = 1'b0;
    wait_ack(1'b0, 20, ok, cyc);
    check("bp_fifth_drop", 32'(ok), 32'd1);
    check("bp_full_again", 32'(fill_level), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain", 32'(out_data), 32'(bp_drain[i]));
      tick();
    end
    out_ready = 1'b0;
    check("bp_empty", 32'(fill_level), 32'd0);

    // Wrap-around with a consumer that is always ready
    pop_log.delete();
    max_fill  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) transfer(wrap_tab[i], 30);
    repeat (2) tick();
    check("wrap_count", 32'(pop_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++)
      check("wrap_order", 32'(pop_log[i]), 32'(wrap_tab[i]));
    check("wrap_max_fill_le1", 32'(max_fill <= 1), 32'd1);
    out_ready = 1'b0;

    // Grant and pop on the same edge
    transfer(8'h21, 20);
    transfer(8'h22, 20);
    grant_mode = 0;
    grant  = 1'b0;
    a_data = 8'h23;
    a_req  = 1'b1;
    wait_req(20, ok);
    check("simul_req", 32'(ok), 32'd1);
    grant     = 1'b1;
    out_ready = 1'b1;
    tick();
    grant     = 1'b0;
    out_ready = 1'b0;
    check("simul_fill", 32'(fill_level), 32'd2);
    check("simul_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    wait_ack(1'b0, 20, ok, cyc);
    check("simul_drop", 32'(ok), 32'd1);
    out_ready = 1'b1;
    check("simul_head0", 32'(out_data), 32'h22);
    tick();
    check("simul_head1", 32'(out_data), 32'h23);
    tick();
    out_ready = 1'b0;
    check("simul_empty", 32'(fill_level), 32'd0);

    // Spurious grant while idle
    grant_mode = 1;
    transfer(8'h31, 20);
    grant_mode = 0;
    grant = 1'b1;
    repeat (3) tick();
    grant = 1'b0;
    check("spur_fill", 32'(fill_level), 32'd1);
    check("spur_ack", 32'(a_ack), 32'd0);
    check("spur_req", 32'(req), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in REQUEST with three words buffered
    grant_mode = 1;
    transfer(8'h41, 20);
    transfer(8'h42, 20);
    transfer(8'h43, 20);
    grant_mode = 0;
    grant  = 1'b0;
    a_data = 8'h44;
    a_req  = 1'b1;
    wait_req(20, ok);
    check("rstmid_req_seen", 32'(ok), 32'd1);
    check("rstmid_fill3", 32'(fill_level), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("rstmid_req", 32'(req), 32'd0);
    check("rstmid_ack", 32'(a_ack), 32'd0);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_fill", 32'(fill_level), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    grant_mode = 1;
    wait_ack(1'b1, 20, ok, cyc);
    check("rstmid_new_ack", 32'(ok), 32'd1);
    check("rstmid_new_fill", 32'(fill_level), 32'd1);
    check("rstmid_new_data", 32'(out_data), 32'h44);
    a_req = 1'b0;
    wait_ack(1'b0, 20, ok, cyc);
    check("rstmid_new_drop", 32'(ok), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized sender, consumer and grant timing
    grant_mode = 2;
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      transfer(8'($urandom), 400);
    end
    rand_ready = 1'b0;
    grant_mode = 0;
    grant      = 1'b0;
    out_ready  = 1'b1;
    repeat (10) tick();
    check("final_empty", 32'(fill_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time %0t", $time);
    $fatal(1);
  end

endmodule
